obstacle_array_logic: RTL and testbench

OBSTACLE_ARRAY_LOGIC -- requirements
Module: obstacle_array_logic

---
 rtl/obstacle_array_logic_if.sv | 29 ++
 rtl/obstacle_array_logic.sv | 84 ++++++++
 tb/tb_obstacle_array_logic.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/obstacle_array_logic_if.sv
// obstacle_array_logic_if: game-control and bird/obstacle geometry bundle for obstacle_array_logic
interface obstacle_array_logic_if #(
  parameter int W       = 10,
  parameter int N_OBS   = 3,
  parameter int SCORE_W = 8
);
  logic               Start;
  logic               Ack;
  logic               Frame_Tick;
  logic [N_OBS*W-1:0] X_Edge;
  logic [N_OBS*W-1:0] Y_Edge;
  logic [W-1:0]       Bird_X;
  logic [W-1:0]       Bird_Y;
  logic               Q_Initial;
  logic               Q_Check;
  logic               Q_Lose;
  logic               Check;
  logic               Lose;
  logic [SCORE_W-1:0] Score;
  logic               Score_Pulse;
  modport master (
    output Start, Ack, Frame_Tick, X_Edge, Y_Edge, Bird_X, Bird_Y,
    input  Q_Initial, Q_Check, Q_Lose, Check, Lose, Score, Score_Pulse
  );
  modport slave (
    input  Start, Ack, Frame_Tick, X_Edge, Y_Edge, Bird_X, Bird_Y,
    output Q_Initial, Q_Check, Q_Lose, Check, Lose, Score, Score_Pulse
  );
endinterface

// File: rtl/obstacle_array_logic.sv
// obstacle_array_logic: bird-vs-pipe collision, game state machine and saturating pass score
module obstacle_array_logic #(
  parameter int W        = 10,
  parameter int N_OBS    = 3,
  parameter int PIPE_W   = 40,
  parameter int GAP_H    = 100,
  parameter int BIRD_SZ  = 16,
  parameter int SCREEN_H = 480,
  parameter int SCORE_W  = 8
) (
  input logic Clk,
  input logic reset,
  obstacle_array_logic_if.slave bus
);
  typedef enum logic [1:0] {INITIAL, CHECK, LOSE} state_t;
  localparam int CW = $clog2(N_OBS + 1);
  localparam int SW = SCORE_W + CW;
  localparam logic signed [W+1:0] PW = (W+2)'(PIPE_W);
  localparam logic signed [W+1:0] GH = (W+2)'(GAP_H);
  localparam logic signed [W+1:0] BS = (W+2)'(BIRD_SZ);
  localparam logic signed [W+1:0] SH = (W+2)'(SCREEN_H);
  localparam logic [SW-1:0] MAX = {{CW{1'b0}}, {SCORE_W{1'b1}}};
  state_t state, next;
  logic [N_OBS-1:0] passed, pass, respawn, hit;
  logic signed [W+1:0] bx, by;
  logic bound, collide, tick;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum;
  logic [SCORE_W-1:0] score;
  logic lose, pulse;
  // Bird coordinates are signed; two guard bits keep every sum below exact
  assign bx = $signed({{2{bus.Bird_X[W-1]}}, bus.Bird_X});
  assign by = $signed({{2{bus.Bird_Y[W-1]}}, bus.Bird_Y});
  for (genvar i = 0; i < N_OBS; i++) begin : g_obs
    logic signed [W+1:0] x, y;
    assign x = $signed({2'b00, bus.X_Edge[i*W +: W]});
    assign y = $signed({2'b00, bus.Y_Edge[i*W +: W]});
    assign hit[i] = bx + BS > x && bx < x + PW && !(by >= y && by + BS <= y + GH);
    assign pass[i] = x + PW < bx && !passed[i];
    assign respawn[i] = x > bx;
  end
  assign bound = by[W+1] || by + BS > SH;
  assign collide = bound || |hit;
  assign tick = state == CHECK && bus.Frame_Tick;
  always_comb begin
    cnt = '0;
    for (int k = 0; k < N_OBS; k++) cnt = cnt + CW'(pass[k]);
  end
  assign sum = SW'(score) + SW'(cnt);
  always_comb begin
    next = state;
    next = state == INITIAL ? (bus.Start ? CHECK : INITIAL)
         : state == CHECK   ? (tick && collide ? LOSE : CHECK)
         :                    (bus.Ack ? INITIAL : LOSE);
  end
  always_ff @(posedge Clk or negedge reset)
    if (!reset) state <= INITIAL;
    else state <= next;
  // Score survives the return to INITIAL and is cleared only by the next Start
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      score  <= '0;
      passed <= '0;
      lose   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      lose  <= tick && collide;
      pulse <= tick && !collide && cnt != '0;
      if (state == INITIAL && bus.Start) begin
        score  <= '0;
        passed <= '0;
      end else if (tick) begin
        passed <= (collide ? passed : passed | pass) & ~respawn;
        if (!collide) score <= sum > MAX ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
      end
    end
  assign bus.Q_Initial   = state == INITIAL;
  assign bus.Q_Check     = state == CHECK;
  assign bus.Q_Lose      = state == LOSE;
  assign bus.Check       = state == CHECK;
  assign bus.Lose        = lose;
  assign bus.Score       = score;
  assign bus.Score_Pulse = pulse;
endmodule

// File: tb/tb_obstacle_array_logic.sv
// tb_obstacle_array_logic: directed and random checks of two DUTs (8-bit and 2-bit score) against a game model
module tb_obstacle_array_logic;
  logic Clk = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;
  obstacle_array_logic_if #(.W(10), .N_OBS(3), .SCORE_W(8)) i0 ();
  obstacle_array_logic_if #(.W(10), .N_OBS(3), .SCORE_W(2)) i1 ();
  obstacle_array_logic #(.SCORE_W(8)) d0 (.Clk(Clk), .reset(reset), .bus(i0));
  obstacle_array_logic #(.SCORE_W(2)) d1 (.Clk(Clk), .reset(reset), .bus(i1));
  assign i1.Start      = i0.Start;
  assign i1.Ack        = i0.Ack;
  assign i1.Frame_Tick = i0.Frame_Tick;
  assign i1.X_Edge     = i0.X_Edge;
  assign i1.Y_Edge     = i0.Y_Edge;
  assign i1.Bird_X     = i0.Bird_X;
  assign i1.Bird_Y     = i0.Bird_Y;
  int checks = 0;
  int errors = 0;
  int mst = 0;
  int s8 = 0;
  int s2 = 0;
  bit [2:0] pf = '0;
  bit e_lose = 0;
  bit e_pulse = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("d0.q_initial", 32'(i0.Q_Initial), 32'(mst == 0));
    chk("d0.q_check", 32'(i0.Q_Check), 32'(mst == 1));
    chk("d0.q_lose", 32'(i0.Q_Lose), 32'(mst == 2));
    chk("d0.check", 32'(i0.Check), 32'(mst == 1));
    chk("d0.lose", 32'(i0.Lose), 32'(e_lose));
    chk("d0.score", 32'(i0.Score), s8);
    chk("d0.pulse", 32'(i0.Score_Pulse), 32'(e_pulse));
    chk("d1.q_initial", 32'(i1.Q_Initial), 32'(mst == 0));
    chk("d1.q_check", 32'(i1.Q_Check), 32'(mst == 1));
    chk("d1.q_lose", 32'(i1.Q_Lose), 32'(mst == 2));
    chk("d1.lose", 32'(i1.Lose), 32'(e_lose));
    chk("d1.score", 32'(i1.Score), s2);
    chk("d1.pulse", 32'(i1.Score_Pulse), 32'(e_pulse));
  endtask
  // Reference: plain integer geometry, one call per clock edge using the inputs present at that edge
  task automatic model();
    int bx, by, x, y, n;
    bit col;
    e_lose = 0;
    e_pulse = 0;
    if (mst == 0) begin
      if (i0.Start) begin
        mst = 1; s8 = 0; s2 = 0; pf = '0;
      end
    end else if (mst == 1) begin
      if (i0.Frame_Tick) begin
        bx = $signed(i0.Bird_X);
        by = $signed(i0.Bird_Y);
        col = by < 0 || by + 16 > 480;
        n = 0;
        for (int i = 0; i < 3; i++) begin
          x = int'(i0.X_Edge[i*10 +: 10]);
          y = int'(i0.Y_Edge[i*10 +: 10]);
          if (bx + 16 > x && bx < x + 40 && !(by >= y && by + 16 <= y + 100)) col = 1;
        end
        for (int i = 0; i < 3; i++) begin
          x = int'(i0.X_Edge[i*10 +: 10]);
          if (!col && x + 40 < bx && !pf[i]) begin
            pf[i] = 1; n++;
          end
          if (x > bx) pf[i] = 0;
        end
        if (col) begin
          mst = 2; e_lose = 1;
        end else begin
          s8 = s8 + n > 255 ? 255 : s8 + n;
          s2 = s2 + n > 3 ? 3 : s2 + n;
          e_pulse = n > 0;
        end
      end
    end else if (i0.Ack) mst = 0;
  endtask
  task automatic model_reset();
    mst = 0; s8 = 0; s2 = 0; pf = '0; e_lose = 0; e_pulse = 0;
  endtask
  task automatic step();
    model();
    @(posedge Clk);
    #1;
    check_all();
  endtask
  task automatic tick_step();
    i0.Frame_Tick = 1'b1;
    step();
    i0.Frame_Tick = 1'b0;
  endtask
  task automatic obs(input int x0, input int y0, input int x1, input int x2);
    i0.X_Edge = {10'(x2), 10'(x1), 10'(x0)};
    i0.Y_Edge = {10'd200, 10'd200, 10'(y0)};
  endtask
  task automatic bird(input int x, input int y);
    i0.Bird_X = 10'(x);
    i0.Bird_Y = 10'(y);
  endtask
  initial begin
    i0.Start = 0; i0.Ack = 0; i0.Frame_Tick = 0;
    obs(1000, 200, 1000, 1000);
    bird(320, 240);
    #2;
    model_reset();
    check_all();
    reset = 1'b1;
    @(posedge Clk);
    #1;
    check_all();
    // Pipe 0 slides left past a bird sitting inside its gap
    i0.Start = 1; step(); i0.Start = 0;
    for (int x = 350; x >= 270; x -= 10) begin
      obs(x, 200, 1000, 1000);
      tick_step();
    end
    chk("req40_score", 32'(i0.Score), 1);
    obs(260, 200, 1000, 1000); tick_step();
    obs(1000, 200, 1000, 1000); tick_step();
    // Pipe overlap with bird outside the gap
    obs(310, 270, 1000, 1000); tick_step();
    chk("req41_lose", 32'(i0.Lose), 1);
    chk("req41_score", 32'(i0.Score), 1);
    step();
    i0.Start = 1; step();
    i0.Ack = 1; step();
    i0.Start = 0; i0.Ack = 0; step();
    chk("req35_init", 32'(i0.Q_Initial), 1);
    i0.Ack = 1; step(); i0.Ack = 0;
    i0.Start = 1; step(); i0.Start = 0;
    // Two pipes pass together, then the narrow score saturates
    obs(250, 200, 260, 1000); tick_step();
    chk("req43_score", 32'(i0.Score), 2);
    obs(1000, 200, 1000, 1000); tick_step();
    obs(200, 200, 200, 200); tick_step();
    obs(1000, 200, 1000, 1000); tick_step();
    obs(200, 200, 1000, 1000); tick_step();
    chk("req44_wide", 32'(i0.Score), 6);
    chk("req44_sat", 32'(i1.Score), 3);
    // Bird falls below the playfield
    obs(1000, 200, 1000, 1000);
    bird(320, 470); tick_step();
    i0.Ack = 1; step(); i0.Ack = 0;
    step();
    chk("req42_held", 32'(i0.Score), 6);
    bird(320, 240);
    i0.Start = 1; i0.Frame_Tick = 1; step(); i0.Start = 0;
    obs(200, 200, 1000, 1000); step();
    obs(1000, 200, 1000, 1000); step();
    // Asynchronous reset in the middle of a tick cycle
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("req45_score", 32'(i0.Score), 0);
    i0.Frame_Tick = 0;
    @(posedge Clk);
    #1;
    check_all();
    reset = 1'b1;
    i0.Start = 1; step(); i0.Start = 0;
    for (int n = 0; n < 400; n++) begin
      i0.Start = $urandom % 6 == 0;
      i0.Ack = $urandom % 4 == 0;
      i0.Frame_Tick = $urandom % 2 == 1;
      i0.X_Edge = 30'($urandom);
      i0.Y_Edge = {10'($urandom_range(100, 220)), 10'($urandom_range(100, 220)), 10'($urandom_range(100, 220))};
      i0.Bird_X = 10'($urandom);
      i0.Bird_Y = $urandom % 8 == 0 ? 10'($urandom) : 10'($urandom_range(150, 300));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
